// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8-entry byte FIFO feeding an 8N1/8E1/8O1/8x2 serialiser.
// Ports: free_clk, rst_n (async low); tx_data/tx_valid/tx_ready write side;
//        uart_txd serial out (idle high); tx_busy, tx_done pulse, fifo_level.
module uart_byte_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       free_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [3:0] fifo_level
);

    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]    mem [8];
    logic [2:0]    wr_ptr;
    logic [2:0]    rd_ptr;
    logic [3:0]    level;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          stop_end;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          txd_q;
    logic          busy_q;
    logic          done_q;

    assign tx_ready   = (level != 4'd8);
    assign fifo_level = level;
    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign head       = mem[rd_ptr];
    assign push       = tx_valid && tx_ready;
    assign stop_end   = (state == STOP) && (cnt == STOP_LAST);
    // The FSM takes a byte either from idle or straight out of the last stop cycle.
    assign pop        = (level != 4'd0) && ((state == IDLE) || stop_end);

    always_ff @(posedge free_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge free_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            level  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            level <= level + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge free_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            par_bit <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (^head) ^ ODD;
                        state   <= START;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        txd_q   <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd_q <= par_bit;
                            end else begin
                                state <= STOP;
                                txd_q <= 1'b1;
                            end
                        end else begin
                            // Line shows bit 0 of the shifted copy; next bit is bit 1.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd_q   <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        txd_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt    <= '0;
                        done_q <= 1'b1;
                        if (pop) begin
                            shreg   <= head;
                            par_bit <= (^head) ^ ODD;
                            state   <= START;
                            txd_q   <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            txd_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50000000: free_clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200: line bit rate.
REQ-003 SHALL provide parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 SHALL provide parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-005 SHALL provide parameter STOP_BITS, default 1: number of stop bits; legal values are 1 and 2.
REQ-006 SHALL provide port free_clk, input, 1 bit: the single clock.
REQ-007 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL provide port tx_data, input, 8 bits: byte to send.
REQ-009 SHALL provide port tx_valid, input, 1 bit: tx_data is valid.
REQ-010 SHALL provide port tx_ready, output, 1 bit: FIFO can accept a byte.
REQ-011 SHALL provide port uart_txd, output, 1 bit: serial line, idle high; drives the uart_rxd of the far end.
REQ-012 SHALL provide port tx_busy, output, 1 bit: high while a frame is being shifted.
REQ-013 SHALL provide port tx_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-014 SHALL provide port fifo_level, output, 4 bits: FIFO occupancy, range 0-8.

Function
REQ-015 SHALL compute DIV = CLK_FREQ/BAUD, truncated; each line bit is held for exactly DIV free_clk cycles (50e6/115200 gives DIV=434).
REQ-016 SHALL hold 8 entries in a first-in, first-out byte FIFO, with tx_ready = (fifo_level != 8).
REQ-017 SHALL write to the FIFO on every rising edge where tx_valid && tx_ready; tx_valid while tx_ready is low is ignored and no byte is lost or duplicated.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: uart_txd=1 and tx_busy=0; if the FIFO is non-empty, pop the head, load the shift register and enter START on the same edge.
REQ-020 START: uart_txd=0 for DIV cycles, then enter DATA.
REQ-021 DATA: send 8 bits LSB first, DIV cycles each, using a 3-bit bit index; after bit 7, enter PARITY if PARITY_EN=1, otherwise STOP.
REQ-022 PARITY: send the XOR of the 8 data bits, inverted when PARITY_ODD=1, for DIV cycles.
REQ-023 STOP: uart_txd=1 for STOP_BITS*DIV cycles.
REQ-024 At the end of STOP: pulse tx_done for 1 cycle; if the FIFO is non-empty, pop and enter START on that same edge with no idle gap; otherwise enter IDLE.
REQ-025 SHALL make the frame length (1+8+PARITY_EN+STOP_BITS)*DIV cycles exactly, with no cycle slip between bits.
REQ-026 Latency: a byte written at edge E into an empty FIFO with the FSM in IDLE SHALL drive uart_txd low from edge E+1.
REQ-027 On a simultaneous push and pop in the same cycle, fifo_level SHALL be unchanged and the popped byte SHALL be the old head.
REQ-028 When fifo_level=8, tx_ready=0; on the edge a pop occurs, tx_ready SHALL rise for the next cycle.
REQ-029 FIFO pointers SHALL be 3 bits wide and wrap 7 to 0 without affecting data order.
REQ-030 uart_txd SHALL be driven from a register, with no combinational glitches.
REQ-031 tx_busy SHALL be 1 in START, DATA, PARITY and STOP.

Reset
REQ-032 While rst_n=0, asynchronously: uart_txd=1, tx_busy=0, tx_done=0, fifo_level=0, tx_ready=1, FSM=IDLE, pointers=0, DIV counter and bit index=0.
REQ-033 On reset mid-frame, SHALL abort the frame immediately, return uart_txd high, and discard all FIFO contents.
REQ-034 After rst_n deasserts, SHALL accept tx_valid from the first rising edge onward.

Verification
REQ-035 Parameters CLK_FREQ=1000000, BAUD=100000 (DIV=10), PARITY_EN=0, STOP_BITS=1; write 0x55 -> uart_txd low at E+1 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles; tx_done pulses at cycle E+101.
REQ-036 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame is 110 cycles.
REQ-037 Burst of 10 bytes 0x00..0x09 with tx_valid held high -> tx_ready drops once the FIFO is full and all 10 bytes are sent in order; frames are back-to-back with no idle between a stop bit and the next start bit; fifo_level never exceeds 8.
REQ-038 Push and pop in the same cycle at fifo_level=3 -> level stays 3; the next frame carries the old head.
REQ-039 Assert rst_n=0 during DATA bit 4 -> uart_txd=1 and fifo_level=0 within the same cycle; after release, a new byte 0xA5 is transmitted correctly.
REQ-040 STOP_BITS=2 -> stop phase lasts 20 cycles; tx_done pulses 1 cycle after the second stop bit.
